// File: rtl/vga_pkg.sv
// Shared raster timing, object geometry, colour codes and latched-position type
// for the Pong VGA scan controller.
package vga_pkg;

    localparam int CLK_DIV_DEF = 2;

    localparam int H_VISIBLE = 640;
    localparam int H_FP      = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BP      = 48;
    localparam int H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;

    localparam int V_VISIBLE = 480;
    localparam int V_FP      = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BP      = 33;
    localparam int V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam int BALL_SIZE = 8;
    localparam int PAD_W     = 8;
    localparam int PAD_H     = 64;
    localparam int LPAD_X    = 16;
    localparam int RPAD_X    = 616;

    localparam logic [2:0] COLOR_WHITE = 3'b000;
    localparam logic [2:0] COLOR_CYAN  = 3'b001;
    localparam logic [2:0] COLOR_RED   = 3'b010;

    typedef struct packed {
        logic [9:0] ball_x;
        logic [9:0] ball_y;
        logic [9:0] lpad_y;
        logic [9:0] rpad_y;
    } pos_t;

    localparam pos_t POS_RST = '{ball_x: 10'd316, ball_y: 10'd236,
                                 lpad_y: 10'd208, rpad_y: 10'd208};

    // 11-bit span test so that lo+len can never wrap back into the raster.
    function automatic logic in_span(input logic [10:0] pos,
                                     input logic [10:0] lo,
                                     input logic [10:0] len);
        return (pos >= lo) && (pos < (lo + len));
    endfunction

endpackage

// File: rtl/vga_scan_counter.sv
// Pixel-rate prescaler plus horizontal/vertical scan counters.
module vga_scan_counter #(
    parameter int CLK_DIV = vga_pkg::CLK_DIV_DEF,
    parameter int H_TOTAL = vga_pkg::H_TOTAL,
    parameter int V_TOTAL = vga_pkg::V_TOTAL
) (
    input  logic       clk,
    input  logic       rst,
    output logic       pix_en,
    output logic [9:0] h_cnt,
    output logic [9:0] v_cnt
);

    logic [9:0] h_cnt_q, h_cnt_d;
    logic [9:0] v_cnt_q, v_cnt_d;

    generate
        if (CLK_DIV <= 1) begin : g_no_div
            assign pix_en = 1'b1;
        end else begin : g_div
            localparam int DIV_W = $clog2(CLK_DIV);
            logic [DIV_W-1:0] div_q, div_d;

            always_comb begin
                div_d = div_q + DIV_W'(1);
                if (div_q == DIV_W'(CLK_DIV - 1)) begin
                    div_d = '0;
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    div_q <= '0;
                end else begin
                    div_q <= div_d;
                end
            end

            assign pix_en = (div_q == DIV_W'(CLK_DIV - 1));
        end
    endgenerate

    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (pix_en) begin
            if (h_cnt_q == 10'(H_TOTAL - 1)) begin
                h_cnt_d = '0;
                if (v_cnt_q == 10'(V_TOTAL - 1)) begin
                    v_cnt_d = '0;
                end else begin
                    v_cnt_d = v_cnt_q + 10'd1;
                end
            end else begin
                h_cnt_d = h_cnt_q + 10'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    assign h_cnt = h_cnt_q;
    assign v_cnt = v_cnt_q;

endmodule

// File: rtl/vga_pong_scan_ctrl.sv
// Pong raster controller: sync generation, per-frame position latch and object
// priority arbitration. Optional top/bottom walls with VGA_PONG_BORDER_EN.
module vga_pong_scan_ctrl #(
    parameter int CLK_DIV   = vga_pkg::CLK_DIV_DEF,
    parameter int H_VISIBLE = vga_pkg::H_VISIBLE,
    parameter int H_FP      = vga_pkg::H_FP,
    parameter int H_SYNC    = vga_pkg::H_SYNC,
    parameter int H_BP      = vga_pkg::H_BP,
    parameter int V_VISIBLE = vga_pkg::V_VISIBLE,
    parameter int V_FP      = vga_pkg::V_FP,
    parameter int V_SYNC    = vga_pkg::V_SYNC,
    parameter int V_BP      = vga_pkg::V_BP,
    parameter int BALL_SIZE = vga_pkg::BALL_SIZE,
    parameter int PAD_W     = vga_pkg::PAD_W,
    parameter int PAD_H     = vga_pkg::PAD_H,
    parameter int LPAD_X    = vga_pkg::LPAD_X,
    parameter int RPAD_X    = vga_pkg::RPAD_X
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] ball_x,
    input  logic [9:0] ball_y,
    input  logic [9:0] lpad_y,
    input  logic [9:0] rpad_y,
    output logic       hsync,
    output logic       vsync,
    output logic       bright,
    output logic       pixel,
    output logic [2:0] colors,
    output logic [9:0] hcount,
    output logic [9:0] vcount,
    output logic       frame_start
);

    import vga_pkg::pos_t;
    import vga_pkg::POS_RST;
    import vga_pkg::in_span;
    import vga_pkg::COLOR_WHITE;
    import vga_pkg::COLOR_CYAN;
    import vga_pkg::COLOR_RED;

    localparam int H_TOT = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC);

    logic       pix_en;
    logic [9:0] h_cnt, v_cnt;

    vga_scan_counter #(
        .CLK_DIV (CLK_DIV),
        .H_TOTAL (H_TOT),
        .V_TOTAL (V_TOT)
    ) u_scan (
        .clk    (clk),
        .rst    (rst),
        .pix_en (pix_en),
        .h_cnt  (h_cnt),
        .v_cnt  (v_cnt)
    );

    pos_t pos_q, pos_d;

    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       bright_q, bright_d;
    logic       pixel_q, pixel_d;
    logic [2:0] colors_q, colors_d;
    logic [9:0] hcount_q, hcount_d;
    logic [9:0] vcount_q, vcount_d;
    logic       frame_start_q, frame_start_d;

    logic [10:0] x_w, y_w;
    logic        ball_hit, lpad_hit, rpad_hit, wall_hit, in_visible;
    logic [2:0]  obj_color;

    assign x_w = {1'b0, h_cnt};
    assign y_w = {1'b0, v_cnt};

    always_comb begin
        ball_hit = in_span(x_w, {1'b0, pos_q.ball_x}, 11'(BALL_SIZE)) &&
                   in_span(y_w, {1'b0, pos_q.ball_y}, 11'(BALL_SIZE));
        lpad_hit = in_span(x_w, 11'(LPAD_X), 11'(PAD_W)) &&
                   in_span(y_w, {1'b0, pos_q.lpad_y}, 11'(PAD_H));
        rpad_hit = in_span(x_w, 11'(RPAD_X), 11'(PAD_W)) &&
                   in_span(y_w, {1'b0, pos_q.rpad_y}, 11'(PAD_H));
`ifdef VGA_PONG_BORDER_EN
        wall_hit = (v_cnt < 10'd4) || (v_cnt >= 10'(V_VISIBLE - 4));
`else
        wall_hit = 1'b0;
`endif
        in_visible = (h_cnt < H_VIS) && (v_cnt < V_VIS);

        // Walls and empty background both fall through to white.
        obj_color = COLOR_WHITE;
        if (ball_hit) begin
            obj_color = COLOR_WHITE;
        end else if (lpad_hit) begin
            obj_color = COLOR_CYAN;
        end else if (rpad_hit) begin
            obj_color = COLOR_RED;
        end
    end

    // Positions are only sampled at the start of vertical blanking, so a frame
    // is always drawn from one consistent set of coordinates.
    always_comb begin
        pos_d = pos_q;
        if (pix_en && (h_cnt == 10'd0) && (v_cnt == V_VIS)) begin
            pos_d.ball_x = ball_x;
            pos_d.ball_y = ball_y;
            pos_d.lpad_y = lpad_y;
            pos_d.rpad_y = rpad_y;
        end
    end

    always_comb begin
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        bright_d      = bright_q;
        pixel_d       = pixel_q;
        colors_d      = colors_q;
        hcount_d      = hcount_q;
        vcount_d      = vcount_q;
        frame_start_d = 1'b0;
        if (pix_en) begin
            hsync_d       = !((h_cnt >= HS_START) && (h_cnt < HS_END));
            vsync_d       = !((v_cnt >= VS_START) && (v_cnt < VS_END));
            bright_d      = in_visible;
            pixel_d       = in_visible && (ball_hit || lpad_hit || rpad_hit || wall_hit);
            colors_d      = in_visible ? obj_color : COLOR_WHITE;
            hcount_d      = h_cnt;
            vcount_d      = v_cnt;
            frame_start_d = (h_cnt == 10'd0) && (v_cnt == 10'd0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos_q         <= POS_RST;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            bright_q      <= 1'b0;
            pixel_q       <= 1'b0;
            colors_q      <= COLOR_WHITE;
            hcount_q      <= '0;
            vcount_q      <= '0;
            frame_start_q <= 1'b0;
        end else begin
            pos_q         <= pos_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            bright_q      <= bright_d;
            pixel_q       <= pixel_d;
            colors_q      <= colors_d;
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign bright      = bright_q;
    assign pixel       = pixel_q;
    assign colors      = colors_q;
    assign hcount      = hcount_q;
    assign vcount      = vcount_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_pong_scan_ctrl.sv
// Scoreboard bench for vga_pong_scan_ctrl on a reduced raster so whole frames fit
// in a short run; the expected stream is derived from elapsed clocks since reset.
module tb_vga_pong_scan_ctrl;

    localparam int CLK_DIV = 2;
    localparam int HV = 40, HF = 4, HS = 8, HB = 4;
    localparam int VV = 30, VF = 2, VS = 2, VB = 2;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FRAME = HT * VT;
    localparam int FRAME_CLKS = FRAME * CLK_DIV;
    localparam int BALL = 3, PW = 4, PH = 8, LX = 2, RX = 34;

    typedef struct packed {
        logic       hsync;
        logic       vsync;
        logic       bright;
        logic       pixel;
        logic [2:0] colors;
        logic [9:0] hcount;
        logic [9:0] vcount;
        logic       frame_start;
    } out_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] ball_x = '0, ball_y = '0, lpad_y = '0, rpad_y = '0;
    logic       hsync, vsync, bright, pixel, frame_start;
    logic [2:0] colors;
    logic [9:0] hcount, vcount;

    vga_pong_scan_ctrl #(
        .CLK_DIV(CLK_DIV), .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .BALL_SIZE(BALL), .PAD_W(PW), .PAD_H(PH), .LPAD_X(LX), .RPAD_X(RX)
    ) dut (
        .clk(clk), .rst(rst),
        .ball_x(ball_x), .ball_y(ball_y), .lpad_y(lpad_y), .rpad_y(rpad_y),
        .hsync(hsync), .vsync(vsync), .bright(bright), .pixel(pixel),
        .colors(colors), .hcount(hcount), .vcount(vcount), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    int   n = 0;
    int   lat_bx = 316, lat_by = 236, lat_ly = 208, lat_ry = 208;
    logic nx_rst = 1'b1;
    logic [9:0] nx_bx = '0, nx_by = '0, nx_ly = '0, nx_ry = '0;
    out_t exp_q[$];
    bit   started = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    function automatic bit inside_box(input int px, input int py, input int ox,
                                      input int oy, input int w, input int h);
        return (px >= ox) && (px < ox + w) && (py >= oy) && (py < oy + h);
    endfunction

    // Expected outputs after n clocks out of reset: pixel k = n/CLK_DIV-1 is shown.
    function automatic out_t expected();
        out_t e;
        int   k, f, x, y;
        bit   bh, lh, rh, wh, vis;
        e = '0;
        e.hsync = 1'b1;
        e.vsync = 1'b1;
        if (n < CLK_DIV) return e;
        k = n / CLK_DIV - 1;
        f = k % FRAME;
        x = f % HT;
        y = f / HT;
        vis = (x < HV) && (y < VV);
        bh = inside_box(x, y, lat_bx, lat_by, BALL, BALL);
        lh = inside_box(x, y, LX, lat_ly, PW, PH);
        rh = inside_box(x, y, RX, lat_ry, PW, PH);
`ifdef VGA_PONG_BORDER_EN
        wh = (y < 4) || (y >= VV - 4);
`else
        wh = 1'b0;
`endif
        e.hcount      = 10'(x);
        e.vcount      = 10'(y);
        e.hsync       = !((x >= HV + HF) && (x < HV + HF + HS));
        e.vsync       = !((y >= VV + VF) && (y < VV + VF + VS));
        e.bright      = vis;
        e.pixel       = vis && (bh || lh || rh || wh);
        e.colors      = (!vis || bh) ? 3'd0 : lh ? 3'd1 : rh ? 3'd2 : 3'd0;
        e.frame_start = (n % CLK_DIV == 0) && (f == 0);
        return e;
    endfunction

    task automatic step();
        int f;
        @(posedge clk);
        if (rst) begin
            n = 0;
        end else begin
            n++;
            if (n % CLK_DIV == 0) begin
                f = (n / CLK_DIV - 1) % FRAME;
                if (f == VV * HT) begin
                    lat_bx = int'(ball_x);
                    lat_by = int'(ball_y);
                    lat_ly = int'(lpad_y);
                    lat_ry = int'(rpad_y);
                end
            end
        end
        #1;
        rst    = nx_rst;
        ball_x = nx_bx;
        ball_y = nx_by;
        lpad_y = nx_ly;
        rpad_y = nx_ry;
        if (rst) begin
            n = 0;
            lat_bx = 316; lat_by = 236; lat_ly = 208; lat_ry = 208;
        end
        exp_q.push_back(expected());
        started = 1'b1;
    endtask

    task automatic run(input int cycles);
        repeat (cycles) step();
    endtask

    initial begin : monitor
        out_t got, want;
        forever begin
            @(negedge clk);
            if (started) begin
                got = {hsync, vsync, bright, pixel, colors, hcount, vcount, frame_start};
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL scoreboard_empty t=%0t got h=%0d v=%0d", $time,
                             got.hcount, got.vcount);
                end else begin
                    want = exp_q.pop_front();
                    if (got !== want) begin
                        n_fail++;
                        $display("FAIL outputs t=%0t got hs=%b vs=%b br=%b px=%b col=%b h=%0d v=%0d fs=%b required hs=%b vs=%b br=%b px=%b col=%b h=%0d v=%0d fs=%b",
                                 $time, got.hsync, got.vsync, got.bright, got.pixel,
                                 got.colors, got.hcount, got.vcount, got.frame_start,
                                 want.hsync, want.vsync, want.bright, want.pixel,
                                 want.colors, want.hcount, want.vcount, want.frame_start);
                    end
                end
            end
        end
    end

    int set_bx[6] = '{10, 3, 38, 1022, 35, 0};
    int set_by[6] = '{5, 12, 28, 1022, 2, 0};
    int set_ly[6] = '{20, 10, 0, 1020, 15, 0};
    int set_ry[6] = '{0, 25, 25, 1023, 0, 0};

    initial begin : stimulus
        nx_rst = 1'b1;
        run(3);
        nx_rst = 1'b0;
        run(300);
        // Reset mid-line, then restart the scan from (0,0).
        nx_rst = 1'b1;
        run(2);
        nx_rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i < 6) begin
                nx_bx = 10'(set_bx[i]);
                nx_by = 10'(set_by[i]);
                nx_ly = 10'(set_ly[i]);
                nx_ry = 10'(set_ry[i]);
            end else begin
                nx_bx = 10'($urandom_range(0, HV + 4));
                nx_by = 10'($urandom_range(0, VV + 4));
                nx_ly = 10'($urandom_range(0, VV));
                nx_ry = 10'($urandom_range(0, VV));
            end
            run(FRAME_CLKS);
            // Move the ball mid-frame; only the next latch may pick it up.
            nx_bx = 10'($urandom_range(0, HV + 8));
            run(FRAME_CLKS / 2);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain left=%0d required=0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
